uart_cmd_rx: RTL

//  Receive half of the board UART link; the transmit half already sends sensor data on RsTx.

---
 rtl/uart_cmd_pkg.sv | 41 ++++
 rtl/uart_rx_core.sv | 118 +++++++++++
 rtl/uart_cmd_rx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and helpers for the
// UART command receiver.
package uart_cmd_pkg;

  localparam logic [7:0] CH_U  = 8'h55;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam int BTN_U = 4;
  localparam int BTN_C = 3;
  localparam int BTN_L = 2;
  localparam int BTN_R = 1;
  localparam int BTN_D = 0;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_D1,
    P_D2,
    P_CR
  } p_state_t;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchronizer, oversample tick
// generator and bit-level FSM.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int DIV        = 651,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0] T_HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] T_FULL = 4'(OVERSAMPLE - 1);

  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  rx_state_t     st;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Sync flops reset to the idle level so reset never fakes a start bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= RX_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        unique case (st)
          RX_IDLE: begin
            if (!rx_s) begin
              st       <= RX_START;
              tick_cnt <= '0;
            end
          end
          RX_START: begin
            if (tick_cnt == T_HALF) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              st       <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          RX_DATA: begin
            if (tick_cnt == T_FULL) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[7:1]};
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) st <= RX_STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          RX_STOP: begin
            if (tick_cnt == T_FULL) begin
              tick_cnt <= '0;
              if (rx_s) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                st       <= RX_IDLE;
              end else begin
                frame_err <= 1'b1;
                st        <= RX_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          RX_BREAK: begin
            if (rx_s) st <= RX_IDLE;
          end
          default: st <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receive half with ASCII command parser: button
// pulses and "Tnn<CR>" set-temperature commands.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int TEM_MIN    = 10,
  parameter int TEM_MAX    = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [4:0] cmd_button,
  output logic       tem_set_valid,
  output logic [7:0] tem_set_value,
  output logic       cmd_err
);

  localparam int SAMP = BAUD * OVERSAMPLE;
  localparam int DIV  = (CLK_HZ + SAMP / 2) / SAMP;
  localparam logic [6:0] TMIN = 7'(TEM_MIN);
  localparam logic [6:0] TMAX = 7'(TEM_MAX);

  p_state_t   ps;
  logic [6:0] acc;
  logic [7:0] up;
  logic [3:0] dig;
  logic [4:0] btn;
  logic       is_dig;
  logic       is_t;
  logic       is_eol;
  logic       is_cr;
  logic       in_range;

  uart_rx_core #(
    .DIV        (DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always_comb begin
    up       = to_upper(rx_data);
    is_dig   = (rx_data >= CH_0) && (rx_data <= CH_9);
    dig      = 4'(rx_data - CH_0);
    is_t     = (up == CH_T);
    is_cr    = (rx_data == CH_CR);
    is_eol   = is_cr || (rx_data == CH_LF);
    in_range = (acc >= TMIN) && (acc <= TMAX);
    btn      = '0;
    unique case (up)
      CH_U:    btn[BTN_U] = 1'b1;
      CH_C:    btn[BTN_C] = 1'b1;
      CH_L:    btn[BTN_L] = 1'b1;
      CH_R:    btn[BTN_R] = 1'b1;
      CH_D:    btn[BTN_D] = 1'b1;
      default: btn = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ps            <= P_IDLE;
      acc           <= '0;
      cmd_button    <= '0;
      tem_set_valid <= 1'b0;
      tem_set_value <= 8'd25;
      cmd_err       <= 1'b0;
    end else begin
      cmd_button    <= '0;
      tem_set_valid <= 1'b0;
      cmd_err       <= 1'b0;
      if (frame_err) begin
        ps <= P_IDLE;
      end else if (rx_valid) begin
        unique case (ps)
          P_IDLE: begin
            unique case (1'b1)
              (|btn):  cmd_button <= btn;
              is_t:    ps <= P_D1;
              is_eol:  ps <= P_IDLE;
              default: cmd_err <= 1'b1;
            endcase
          end
          P_D1, P_D2: begin
            unique case (1'b1)
              is_t: ps <= P_D1;
              is_dig: begin
                if (ps == P_D1) begin
                  acc <= {3'b0, dig};
                  ps  <= P_D2;
                end else begin
                  acc <= 7'(acc * 7'd10) + {3'b0, dig};
                  ps  <= P_CR;
                end
              end
              default: begin
                cmd_err <= 1'b1;
                ps      <= P_IDLE;
              end
            endcase
          end
          P_CR: begin
            ps <= P_IDLE;
            unique case (1'b1)
              is_t: ps <= P_D1;
              is_cr: begin
                if (in_range) begin
                  tem_set_value <= {1'b0, acc};
                  tem_set_valid <= 1'b1;
                end else begin
                  cmd_err <= 1'b1;
                end
              end
              default: cmd_err <= 1'b1;
            endcase
          end
          default: ps <= P_IDLE;
        endcase
      end
    end
  end

endmodule
